reservation_station: RTL and testbench
======================================

# reservation_station

Operand-buffering reservation station downstream of ID-stage operand generation. Accepts decoded micro-ops whose two operands are each a value or a rename reference (ROB tag), captures missing values from the common data bus (CDB), and issues ready entries oldest-first to a functional unit through a valid/ready handshake. Flush empties it on misprediction or exception.

## Interface
- ENTRY_NUM, 4: entry count, power of two, ≥2
- TAG_WIDTH, 4: ROB tag width
- DATA_WIDTH, 32: operand width
- OP_WIDTH, 8: micro-op code width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  upstream offers a micro-op
- in_ready  out  1  free entry available
- in_op  in  OP_WIDTH  micro-op code
- in_dest_tag  in  TAG_WIDTH  ROB tag of the micro-op
- in_is_ref_1 / in_is_ref_2  in  1  operand holds a tag, not a value
- in_data_1 / in_data_2  in  DATA_WIDTH  value, or tag in bits [TAG_WIDTH-1:0] when is_ref
- cdb_valid  in  1  result broadcast this cycle
- cdb_tag  in  TAG_WIDTH  producer tag
- cdb_data  in  DATA_WIDTH  produced value
- out_valid  out  1  ready entry selected
- out_ready  in  1  functional unit accepts
- out_op  out  OP_WIDTH; out_dest_tag  out  TAG_WIDTH; out_data_1 / out_data_2  out  DATA_WIDTH  selected entry contents

## Operation
- Entry state: valid, op, dest_tag, per operand {waiting, tag, value}. Entry ready = valid and neither operand waiting (registered state only).
- Insert when in_valid && in_ready: into lowest-index free entry. Operand with is_ref=0 stored as value, waiting=0. is_ref=1: if cdb_valid and cdb_tag equals the operand tag in the same cycle, store cdb_data, waiting=0; else waiting=1 with tag.
- Wakeup: each cycle, every waiting operand of a valid entry with tag == cdb_tag (cdb_valid=1) captures cdb_data, clears waiting. Both operands of one entry may wake together.
- Select: among ready entries, the oldest (see Configuration). out_* driven combinationally from that entry; all out_* are 0 when out_valid=0.
- Issue when out_valid && out_ready: selected entry invalidated at the edge.
- in_ready = !(all entries valid); does not depend on out_ready (no same-cycle freed-slot reuse).
- Insert and issue may occur in the same cycle on different entries.
- flush=1: all entries invalid at next edge; insert and issue in that cycle suppressed; out_valid and in_ready forced 0 during the flush cycle.
- Age matrix older[i][j]: on insertion into k, older[k][j]=0 for all j, older[i][k]=1 for every other valid i. Invalid entries ignored in select.

## Timing
- Reset (async, immediate): all entries invalid, age matrix 0; out_valid=0, out_* =0, in_ready=0 while rst high, 1 from the first cycle after deassertion.
- Insert at edge t with both operands ready (or bypassed from CDB) → out_valid=1 in cycle t+1.
- CDB wakeup at edge t → entry eligible in cycle t+1; no wakeup-to-issue in the broadcast cycle.
- Full: in_ready=0 until an issue edge frees an entry; in_ready=1 the following cycle.
- out_valid=1 with out_ready=0: selection may change next cycle only if an older entry becomes ready.
- Reset mid-operation discards all entries; no partial state survives.

## Configuration
- RS_AGE_ORDER_EN defined: age matrix maintained; select picks the ready entry with no older ready entry.
- Undefined: no age matrix; select picks the lowest-index ready entry. All other behaviour identical.

## Test plan
- Reset then insert op=0x21, dest=3, values 5 and 7 → next cycle out_valid=1, out_data_1=5, out_data_2=7, out_dest_tag=3; issue with out_ready=1 → out_valid=0.
- Insert op1 with in_is_ref_1=1 tag 9; two cycles later cdb_valid tag 9 data 0xDEADBEEF → out_valid rises one cycle after broadcast, out_data_1=0xDEADBEEF.
- Insert with ref tag 6 while cdb_valid tag 6 data 0x55 same cycle → out_valid next cycle, out_data_1=0x55.
- Fill 4 entries all waiting, out_ready=1 → in_ready=0, 5th in_valid ignored; wake entry 2 → issued, in_ready=1 next cycle.
- With RS_AGE_ORDER_EN: insert A (waiting) into entry 0, B ready into entry 1, issue B, insert C ready into entry 1, wake A → A issues before C; without the macro, A (entry 0) also first; reinsertion order swapped differentiates.
- Flush with 3 valid entries and in_valid=1 → out_valid=0, in_ready=0 that cycle; next cycle empty, in_ready=1.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: operand-buffering reservation station.
// Holds decoded micro-ops until both operands are available (captured from
// the CDB), then issues ready entries oldest-first over a valid/ready port.
// Optional feature macro: RS_AGE_ORDER_EN -- when defined an age matrix
// orders issue oldest-first; when undefined the lowest-index ready entry wins.
// Ports:
//   clk, rst (async, active-high), flush (sync clear of all entries)
//   in_valid/in_ready, in_op, in_dest_tag, in_is_ref_1/2, in_data_1/2 : insert
//   cdb_valid, cdb_tag, cdb_data                                      : wakeup
//   out_valid/out_ready, out_op, out_dest_tag, out_data_1/2           : issue
module reservation_station #(
  parameter int unsigned ENTRY_NUM  = 4,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [TAG_WIDTH-1:0]  in_dest_tag,
  input  logic                  in_is_ref_1,
  input  logic                  in_is_ref_2,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH-1:0]   out_op,
  output logic [TAG_WIDTH-1:0]  out_dest_tag,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2
);

  localparam int unsigned IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  // Entry storage
  logic [ENTRY_NUM-1:0]  valid_q;
  logic [ENTRY_NUM-1:0]  wait1_q;
  logic [ENTRY_NUM-1:0]  wait2_q;
  logic [OP_WIDTH-1:0]   op_q   [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  dest_q [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag1_q [ENTRY_NUM];
  logic [TAG_WIDTH-1:0]  tag2_q [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] data1_q[ENTRY_NUM];
  logic [DATA_WIDTH-1:0] data2_q[ENTRY_NUM];

`ifdef RS_AGE_ORDER_EN
  // older_q[i][j] = 1 means entry i was inserted before entry j
  logic [ENTRY_NUM-1:0]  older_q[ENTRY_NUM];
  logic                  has_older;
`endif

  logic [ENTRY_NUM-1:0]  ready;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      free_idx;
  logic                  full;
  logic                  do_insert;
  logic                  do_issue;
  logic [TAG_WIDTH-1:0]  in_tag_1;
  logic [TAG_WIDTH-1:0]  in_tag_2;

  assign in_tag_1 = in_data_1[TAG_WIDTH-1:0];
  assign in_tag_2 = in_data_2[TAG_WIDTH-1:0];

  // Free-slot search, issue selection and handshake decode
  always_comb begin
    ready     = valid_q & ~wait1_q & ~wait2_q;
    full      = &valid_q;
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    has_older = 1'b0;
`endif
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
`ifdef RS_AGE_ORDER_EN
      // An entry wins only if no ready entry is older than it
      has_older = 1'b0;
      for (int j = 0; j < ENTRY_NUM; j++) begin
        if (ready[j] && older_q[j][i]) has_older = 1'b1;
      end
      if (ready[i] && !has_older && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`else
      if (ready[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
    end
    in_ready  = !rst && !flush && !full;
    out_valid = sel_found && !flush && !rst;
    do_insert = in_valid && in_ready;
    do_issue  = out_valid && out_ready;
    out_op       = out_valid ? op_q[sel_idx]    : '0;
    out_dest_tag = out_valid ? dest_q[sel_idx]  : '0;
    out_data_1   = out_valid ? data1_q[sel_idx] : '0;
    out_data_2   = out_valid ? data2_q[sel_idx] : '0;
  end

  // Entry state: wakeup, issue invalidation, insertion with CDB bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wait1_q <= '0;
      wait2_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        op_q[i]    <= '0;
        dest_q[i]  <= '0;
        tag1_q[i]  <= '0;
        tag2_q[i]  <= '0;
        data1_q[i] <= '0;
        data2_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
        older_q[i] <= '0;
`endif
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (cdb_valid && valid_q[i] && wait1_q[i] && (tag1_q[i] == cdb_tag)) begin
          data1_q[i] <= cdb_data;
          wait1_q[i] <= 1'b0;
        end
        if (cdb_valid && valid_q[i] && wait2_q[i] && (tag2_q[i] == cdb_tag)) begin
          data2_q[i] <= cdb_data;
          wait2_q[i] <= 1'b0;
        end
      end
      if (do_issue) valid_q[sel_idx] <= 1'b0;
      if (do_insert) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= in_op;
        dest_q[free_idx]  <= in_dest_tag;
        tag1_q[free_idx]  <= in_tag_1;
        tag2_q[free_idx]  <= in_tag_2;
        if (!in_is_ref_1) begin
          data1_q[free_idx] <= in_data_1;
          wait1_q[free_idx] <= 1'b0;
        end else if (cdb_valid && (cdb_tag == in_tag_1)) begin
          data1_q[free_idx] <= cdb_data;
          wait1_q[free_idx] <= 1'b0;
        end else begin
          data1_q[free_idx] <= '0;
          wait1_q[free_idx] <= 1'b1;
        end
        if (!in_is_ref_2) begin
          data2_q[free_idx] <= in_data_2;
          wait2_q[free_idx] <= 1'b0;
        end else if (cdb_valid && (cdb_tag == in_tag_2)) begin
          data2_q[free_idx] <= cdb_data;
          wait2_q[free_idx] <= 1'b0;
        end else begin
          data2_q[free_idx] <= '0;
          wait2_q[free_idx] <= 1'b1;
        end
`ifdef RS_AGE_ORDER_EN
        // New entry is younger than every currently valid entry
        for (int i = 0; i < ENTRY_NUM; i++) begin
          if (IDX_W'(i) == free_idx) older_q[i] <= '0;
          else older_q[i][free_idx] <= valid_q[i];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus a randomized run checked
// against an insertion-sequence-ordered behavioural model of the station.
module tb_reservation_station;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_op;
  logic [TW-1:0] in_dest_tag;
  logic          in_is_ref_1, in_is_ref_2;
  logic [DW-1:0] in_data_1, in_data_2;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_op;
  logic [TW-1:0] out_dest_tag;
  logic [DW-1:0] out_data_1, out_data_2;

  int checks   = 0;
  int failures = 0;

  reservation_station #(
    .ENTRY_NUM(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .OP_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dest_tag(in_dest_tag), .in_is_ref_1(in_is_ref_1), .in_is_ref_2(in_is_ref_2),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_dest_tag(out_dest_tag), .out_data_1(out_data_1), .out_data_2(out_data_2)
  );

  always #5 clk = ~clk;

`ifdef RS_AGE_ORDER_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_op = '0; in_dest_tag = '0;
    in_is_ref_1 = 0; in_is_ref_2 = 0; in_data_1 = '0; in_data_2 = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; out_ready = 0;
  endtask

  task automatic offer(input logic [OW-1:0] op, input logic [TW-1:0] dest,
                       input logic r1, input logic [DW-1:0] d1,
                       input logic r2, input logic [DW-1:0] d2);
    in_valid = 1; in_op = op; in_dest_tag = dest;
    in_is_ref_1 = r1; in_data_1 = d1; in_is_ref_2 = r2; in_data_2 = d2;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hold in_ready=%0b out_valid=%0b exp 0/0", in_ready, out_valid);
    end
    tick(); tick();
    rst = 0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data_1 !== '0) begin
      failures++; $display("FAIL reset_release in_ready=%0b out_valid=%0b d1=%h exp 1/0/0", in_ready, out_valid, out_data_1);
    end
    // Asynchronous reset mid-operation discards a ready entry immediately
    offer(8'h11, 4'd1, 0, 32'd1, 0, 32'd2);
    tick(); in_valid = 0; #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL reset_pre_valid got=%0b exp=1", out_valid);
    end
    #2 rst = 1; #1;
    checks++;
    if (out_valid !== 1'b0 || out_dest_tag !== '0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_async out_valid=%0b dest=%0d in_ready=%0b exp 0/0/0", out_valid, out_dest_tag, in_ready);
    end
    tick(); rst = 0; tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_discard out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    idle();
    offer(8'h21, 4'd3, 0, 32'd5, 0, 32'd7);
    tick(); in_valid = 0; #1;
    checks++;
    if ({out_valid, out_op, out_dest_tag, out_data_1, out_data_2} !== {1'b1, 8'h21, 4'd3, 32'd5, 32'd7}) begin
      failures++; $display("FAIL basic_out v=%0b op=%h dest=%0d d1=%0d d2=%0d exp 1/21/3/5/7",
                           out_valid, out_op, out_dest_tag, out_data_1, out_data_2);
    end
    out_ready = 1; tick(); out_ready = 0; #1;
    checks++;
    if (out_valid !== 1'b0 || out_data_1 !== '0) begin
      failures++; $display("FAIL basic_issue v=%0b d1=%h exp 0/0", out_valid, out_data_1);
    end
  endtask

  task automatic test_cdb_wakeup();
    idle();
    offer(8'h30, 4'd4, 1, 32'hFFFF_FFF9, 0, 32'd1);
    tick(); in_valid = 0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL wake_wait got=%0b exp=0", out_valid);
    end
    tick();
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'hDEADBEEF; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL wake_same_cycle got=%0b exp=0", out_valid);
    end
    tick(); cdb_valid = 0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_data_1 !== 32'hDEADBEEF || out_data_2 !== 32'd1) begin
      failures++; $display("FAIL wake_capture v=%0b d1=%h d2=%h exp 1/deadbeef/1", out_valid, out_data_1, out_data_2);
    end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_bypass();
    idle();
    offer(8'h40, 4'd5, 1, 32'd6, 0, 32'd2);
    cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 32'h55;
    tick(); in_valid = 0; cdb_valid = 0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_data_1 !== 32'h55 || out_dest_tag !== 4'd5) begin
      failures++; $display("FAIL bypass v=%0b d1=%h dest=%0d exp 1/55/5", out_valid, out_data_1, out_dest_tag);
    end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 4; i++) begin
      offer(OW'(8'h50 + i), TW'(i + 1), 1, DW'(i + 1), 0, 32'd0);
      tick();
    end
    in_valid = 0; #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL full_state in_ready=%0b out_valid=%0b exp 0/0", in_ready, out_valid);
    end
    out_ready = 1;
    offer(8'h99, 4'd15, 0, 32'd9, 0, 32'd9);
    tick(); in_valid = 0; #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL full_reject in_ready=%0b out_valid=%0b exp 0/0", in_ready, out_valid);
    end
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'h1234;
    tick(); cdb_valid = 0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_dest_tag !== 4'd3 || out_data_1 !== 32'h1234 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full_wake v=%0b dest=%0d d1=%h in_ready=%0b exp 1/3/1234/0",
                           out_valid, out_dest_tag, out_data_1, in_ready);
    end
    tick(); out_ready = 0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL full_free in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_age();
    logic [TW-1:0] exp_dest;
    idle();
    offer(8'hA0, 4'd10, 1, 32'd10, 0, 32'd0); tick();
    offer(8'hB0, 4'd11, 0, 32'd1, 0, 32'd2); tick();
    in_valid = 0; #1;
    checks++;
    if (out_dest_tag !== 4'd11) begin
      failures++; $display("FAIL age_b got=%0d exp=11", out_dest_tag);
    end
    out_ready = 1; tick(); out_ready = 0;
    offer(8'hC0, 4'd12, 0, 32'd3, 0, 32'd4); tick();
    in_valid = 0; #1;
    checks++;
    if (out_dest_tag !== 4'd12) begin
      failures++; $display("FAIL age_c got=%0d exp=12", out_dest_tag);
    end
    cdb_valid = 1; cdb_tag = 4'd10; cdb_data = 32'hAAAA;
    tick(); cdb_valid = 0; #1;
    checks++;
    if (out_dest_tag !== 4'd10 || out_data_1 !== 32'hAAAA) begin
      failures++; $display("FAIL age_a_first dest=%0d d1=%h exp 10/aaaa", out_dest_tag, out_data_1);
    end
    out_ready = 1; tick(); #1;
    checks++;
    if (out_dest_tag !== 4'd12) begin
      failures++; $display("FAIL age_c_second got=%0d exp=12", out_dest_tag);
    end
    tick(); out_ready = 0;
    // Older entry now lives at the higher index
    offer(8'h01, 4'd1, 0, 32'd1, 0, 32'd1); tick();
    offer(8'h02, 4'd2, 1, 32'd5, 0, 32'd1); tick();
    in_valid = 0;
    out_ready = 1; tick(); out_ready = 0;
    offer(8'h03, 4'd3, 0, 32'd1, 0, 32'd1); tick();
    in_valid = 0;
    cdb_valid = 1; cdb_tag = 4'd5; cdb_data = 32'h77;
    tick(); cdb_valid = 0; #1;
    exp_dest = AGE ? 4'd2 : 4'd3;
    checks++;
    if (out_dest_tag !== exp_dest) begin
      failures++; $display("FAIL age_order got=%0d exp=%0d", out_dest_tag, exp_dest);
    end
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_flush();
    idle();
    offer(8'h61, 4'd1, 1, 32'd2, 0, 32'd0); tick();
    offer(8'h62, 4'd2, 0, 32'd3, 0, 32'd0); tick();
    offer(8'h63, 4'd3, 1, 32'd4, 1, 32'd4); tick();
    offer(8'h64, 4'd4, 0, 32'd5, 0, 32'd6);
    flush = 1; out_ready = 1; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_cycle out_valid=%0b in_ready=%0b exp 0/0", out_valid, in_ready);
    end
    tick(); flush = 0; in_valid = 0; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_after out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
    out_ready = 0;
  endtask

  // Behavioural model: entries carry an insertion sequence number
  bit            m_v [N];
  bit            m_w1[N], m_w2[N];
  logic [TW-1:0] m_t1[N], m_t2[N];
  logic [DW-1:0] m_d1[N], m_d2[N];
  logic [OW-1:0] m_op[N];
  logic [TW-1:0] m_dt[N];
  int            m_seq[N];
  int            seq_ctr;

  task automatic test_random();
    int  pick, nfree, slot;
    bit  exp_ir, exp_ov;
    logic [OW+TW+2*DW:0] exp_vec, got_vec;
    idle();
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < N; i++) m_v[i] = 0;
    seq_ctr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      flush       = ($urandom_range(0, 39) == 0);
      in_valid    = $urandom_range(0, 1);
      in_op       = OW'($urandom);
      in_dest_tag = TW'($urandom);
      in_is_ref_1 = $urandom_range(0, 1);
      in_is_ref_2 = $urandom_range(0, 2) == 0;
      in_data_1   = in_is_ref_1 ? {$urandom_range(0, 255), 24'h0} | DW'($urandom_range(0, 3)) : $urandom;
      in_data_2   = in_is_ref_2 ? DW'($urandom_range(0, 3)) : $urandom;
      cdb_valid   = $urandom_range(0, 1);
      cdb_tag     = TW'($urandom_range(0, 3));
      cdb_data    = $urandom;
      out_ready   = $urandom_range(0, 2) != 0;
      #1;
      // Expected outputs from current model state
      nfree = 0; slot = -1; pick = -1;
      for (int i = 0; i < N; i++) begin
        if (!m_v[i]) begin nfree++; if (slot < 0) slot = i; end
        if (m_v[i] && !m_w1[i] && !m_w2[i]) begin
          if (pick < 0) pick = i;
          else if (AGE && m_seq[i] < m_seq[pick]) pick = i;
        end
      end
      exp_ir = !flush && (nfree > 0);
      exp_ov = !flush && (pick >= 0);
      exp_vec = exp_ov ? {1'b1, m_op[pick], m_dt[pick], m_d1[pick], m_d2[pick]} : '0;
      got_vec = {out_valid, out_op, out_dest_tag, out_data_1, out_data_2};
      checks++;
      if (in_ready !== exp_ir) begin
        failures++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ir);
      end
      checks++;
      if (got_vec !== exp_vec) begin
        failures++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      // Advance model to the next edge
      if (flush) begin
        for (int i = 0; i < N; i++) m_v[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_v[i] && cdb_valid && m_w1[i] && m_t1[i] == cdb_tag) begin m_w1[i] = 0; m_d1[i] = cdb_data; end
          if (m_v[i] && cdb_valid && m_w2[i] && m_t2[i] == cdb_tag) begin m_w2[i] = 0; m_d2[i] = cdb_data; end
        end
        if (exp_ov && out_ready) m_v[pick] = 0;
        if (in_valid && exp_ir) begin
          m_v[slot] = 1; m_op[slot] = in_op; m_dt[slot] = in_dest_tag;
          m_seq[slot] = seq_ctr; seq_ctr++;
          m_t1[slot] = in_data_1[TW-1:0]; m_t2[slot] = in_data_2[TW-1:0];
          m_w1[slot] = in_is_ref_1 && !(cdb_valid && cdb_tag == in_data_1[TW-1:0]);
          m_w2[slot] = in_is_ref_2 && !(cdb_valid && cdb_tag == in_data_2[TW-1:0]);
          m_d1[slot] = !in_is_ref_1 ? in_data_1 : (m_w1[slot] ? '0 : cdb_data);
          m_d2[slot] = !in_is_ref_2 ? in_data_2 : (m_w2[slot] ? '0 : cdb_data);
        end
      end
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_bypass();
    test_full();
    test_age();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
